// File: rtl/risky1_io_bridge.sv
// Purpose : routes the RisKy1 core's single External I/O port to one of 2**SEL_W device channels.
// Latency : request to ch_req 1 cycle; device ack/fault to io_ack/io_ack_fault 1 cycle (minimum 2 overall).
// Backpressure: one transaction at a time; the core holds io_req until the ack/fault pulse, then must drop it.
//
// Ports:
//   clk_in, reset_in                  clock, asynchronous active-low reset
//   io_req/io_addr/io_rd/io_wr/io_wr_data  core request side
//   io_ack/io_ack_fault/io_rd_data    core response side (one-cycle pulses, registered)
//   ch_req/ch_addr/ch_rd/ch_wr/ch_wr_data  device request side (one-hot req, shared payload)
//   ch_ack/ch_fault/ch_rd_data        per-channel device responses
//   timeout_cnt                       saturating count of timed-out transactions
module risky1_io_bridge #(
    parameter int PC_SZ     = 32,
    parameter int RSZ       = 32,
    parameter int SEL_W     = 2,
    parameter int SEL_LSB   = 12,
    parameter int TO_CYCLES = 64,
    localparam int N_CH     = 1 << SEL_W
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  io_req,
    input  logic [PC_SZ-1:0]      io_addr,
    input  logic                  io_rd,
    input  logic                  io_wr,
    input  logic [RSZ-1:0]        io_wr_data,
    output logic                  io_ack,
    output logic                  io_ack_fault,
    output logic [RSZ-1:0]        io_rd_data,
    output logic [N_CH-1:0]       ch_req,
    output logic [PC_SZ-1:0]      ch_addr,
    output logic                  ch_rd,
    output logic                  ch_wr,
    output logic [RSZ-1:0]        ch_wr_data,
    input  logic [N_CH-1:0]       ch_ack,
    input  logic [N_CH-1:0]       ch_fault,
    input  logic [N_CH*RSZ-1:0]   ch_rd_data,
    output logic [15:0]           timeout_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // The counter must be able to hold TO_CYCLES itself; see the REQ timeout branch.
    localparam int CNT_W = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TO_CYCLES);

    logic [1:0]       state;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] io_sel;
    logic             sel_ack;
    logic             sel_fault;
    logic [RSZ-1:0]   sel_rd_data;

    assign io_sel    = io_addr[SEL_LSB +: SEL_W];
    // Only the latched channel is ever looked at; other channels' strobes are ignored.
    assign sel_ack   = ch_ack[sel];
    assign sel_fault = ch_fault[sel];

    always_comb begin
        sel_rd_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_rd_data = ch_rd_data[k*RSZ +: RSZ];
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state        <= IDLE;
            sel          <= '0;
            cnt          <= '0;
            io_ack       <= 1'b0;
            io_ack_fault <= 1'b0;
            io_rd_data   <= '0;
            ch_req       <= '0;
            ch_addr      <= '0;
            ch_rd        <= 1'b0;
            ch_wr        <= 1'b0;
            ch_wr_data   <= '0;
            timeout_cnt  <= '0;
        end else begin
            // Response strobes are single-cycle: cleared unless set below.
            io_ack       <= 1'b0;
            io_ack_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_req) begin
                        ch_addr    <= io_addr;
                        ch_rd      <= io_rd;
                        ch_wr      <= io_wr;
                        ch_wr_data <= io_wr_data;
                        sel        <= io_sel;
                        cnt        <= '0;
                        if (io_rd == io_wr) begin
                            // Malformed request: fault straight away, device never sees it.
                            state        <= RESP;
                            io_ack_fault <= 1'b1;
                            io_rd_data   <= '0;
                        end else begin
                            state  <= REQ;
                            ch_req <= N_CH'(1) << io_sel;
                        end
                    end
                end
                REQ: begin
                    if (sel_fault) begin
                        // Fault beats a simultaneous ack.
                        state        <= RESP;
                        ch_req       <= '0;
                        io_ack_fault <= 1'b1;
                        io_rd_data   <= '0;
                    end else if (sel_ack) begin
                        state  <= RESP;
                        ch_req <= '0;
                        io_ack <= 1'b1;
                        if (ch_rd) begin
                            io_rd_data <= sel_rd_data;
                        end
                    end else if ((TO_CYCLES != 0) && (cnt == TO_LIM)) begin
                        // Device had TO_CYCLES unanswered cycles plus the first
                        // ch_req cycle; give up.
                        state        <= RESP;
                        ch_req       <= '0;
                        io_ack_fault <= 1'b1;
                        io_rd_data   <= '0;
                        if (timeout_cnt != 16'hFFFF) begin
                            timeout_cnt <= timeout_cnt + 16'd1;
                        end
                    end else begin
                        // With the timeout disabled this simply wraps and is never compared.
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= DONE;
                end
                DONE: begin
                    // A held request is never re-issued; wait for it to drop.
                    if (!io_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
